interrupt_ack_sequencer: RTL and testbench
==========================================

// Module: interrupt_ack_sequencer
// PURPOSE
//  Control-logic sequencer for the 8259A acknowledge/poll path. Tracks INTA pulses and OCW3 poll reads,
//  and drives control_state into the acknowledge data-bus module. Latches the winning IR level at the
//  first INTA and pulses in-service/EOI strobes to the ISR block. Sits between the bus/priority logic
//  and the acknowledge data-bus module.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  clocks allowed between INTA pulses before abort (used only with ACK_TIMEOUT_EN)
//  CNT_W           $clog2(TIMEOUT_CYCLES+1)  width of the timeout counter (derived, do not override)
// PORTS
//  clock                        in   1  system clock; all logic on rising edge
//  reset                        in   1  synchronous reset, active-high
//  interrupt_acknowledge_n      in   1  INTA#, pre-synchronised, active-low
//  read                         in   1  CPU read strobe, active-high level
//  poll_command                 in   1  1-clk pulse: OCW3 written with P=1
//  icw1_write                   in   1  1-clk pulse: ICW1 written (re-initialisation)
//  u8086_or_mcs80_config        in   1  0 = 8086 (2 INTA), 1 = MCS-80 (3 INTA)
//  auto_eoi_config              in   1  1 = clear ISR bit automatically at end of sequence
//  highest_level_in_request     in   8  one-hot winning IRR bit from priority resolver; 0 = none
//  control_state                out  3  READY=0, ACK1=1, ACK2=2, ACK3=3, POLL=4
//  interrupt_when_ack1          out  8  one-hot level latched at first INTA
//  freeze                       out  1  high from first INTA falling edge to end of sequence; IRR holds
//  latch_in_service             out  8  1-clk one-hot pulse: set ISR bit
//  clear_in_service             out  8  1-clk one-hot pulse: clear ISR bit (auto-EOI)
//  end_of_sequence              out  1  1-clk pulse when ack or poll sequence completes
// BEHAVIOUR
//  - Reset/icw1_write: state READY; all outputs 0; timeout counter 0. icw1_write aborts any sequence, no strobes.
//  - Edges: inta_fall/inta_rise and read_fall from 1-clk registered previous values; reset sets prev INTA=1, read=0.
//  - READY: inta_fall -> ACK1: latch interrupt_when_ack1 = highest_level_in_request, or 8'h80 (spurious IR7)
//    if 0; freeze<=1; latch_in_service = latched value next clock.
//    poll_command -> POLL. inta_fall and poll_command same cycle: inta wins, poll dropped.
//  - ACK1: inta_fall -> ACK2.
//  - ACK2: 8086: inta_rise -> READY + completion. MCS-80: inta_fall -> ACK3.
//  - ACK3: inta_rise -> READY + completion.
//  - Completion (registered, 1 clk after edge): end_of_sequence=1; freeze<=0; if auto_eoi_config,
//    clear_in_service = interrupt_when_ack1 same cycle. interrupt_when_ack1 holds until next ACK1 entry.
//  - POLL: read_fall -> READY; same clock latch_in_service = highest_level_in_request (0 if none, no
//    spurious substitution); end_of_sequence=1. inta_fall in POLL -> treated as READY->ACK1 (poll abandoned).
//  - Spurious path (8'h80): latch_in_service still pulses 8'h80; ISR block may ignore.
//  - Strobe outputs are never asserted two consecutive clocks. control_state changes only on clock edges.
// CONFIGURATION
//  ACK_TIMEOUT_EN defined: counter clears on every INTA edge and in READY/POLL; in ACK1..ACK3 counts up;
//    at TIMEOUT_CYCLES -> READY, freeze<=0, no end_of_sequence, no clear_in_service.
//  ACK_TIMEOUT_EN undefined: no counter; ACK states wait indefinitely for INTA edges.
// STRUCTURE
//  - Package pic8259_pkg: 3-bit state localparams CTL_READY/ACK1/ACK2/ACK3/POLL, SPURIOUS_LEVEL=8'h80.
//    The acknowledge data-bus module decodes the same constants.
//  - Sub-module pic_edge_detect (registered rise/fall pulses), instantiated for INTA# and read.
//  - One state FSM, one strobe register block, optional counter in the ACK_TIMEOUT_EN branch.
// TESTING
//  1 8086: highest=8'h04, two INTA pulses -> states 0,1,2,0; latch_in_service=8'h04 1 clk after 1st fall;
//    end_of_sequence 1 clk after 2nd rise; interrupt_when_ack1=8'h04.
//  2 MCS-80 + auto_eoi=1: highest=8'h10, three INTA pulses -> ACK3 reached;
//    clear_in_service=8'h10 with end_of_sequence.
//  3 Spurious: highest=0 at 1st INTA fall -> interrupt_when_ack1=8'h80, latch_in_service=8'h80.
//  4 Poll: poll_command, highest=8'h02, read 1->0 -> POLL then READY; latch_in_service=8'h02;
//    poll with highest=0 -> latch_in_service=0, end_of_sequence=1.
//  5 Abort: icw1_write in ACK2 -> READY next clk, freeze=0, no strobes; reset mid-ACK1 likewise.
//  6 ACK_TIMEOUT_EN, TIMEOUT_CYCLES=16: stall in ACK1 -> READY after 16 clocks, no end_of_sequence.
//    Without macro: still ACK1 at clock 100.

Source files
------------

// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared constants for the 8259A acknowledge path: control_state encoding and spurious level.
// The acknowledge data-bus module decodes the same CTL_* values.
package pic8259_pkg;

  localparam int unsigned LEVEL_W = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] CTL_READY = 3'd0;
  localparam logic [STATE_W-1:0] CTL_ACK1  = 3'd1;
  localparam logic [STATE_W-1:0] CTL_ACK2  = 3'd2;
  localparam logic [STATE_W-1:0] CTL_ACK3  = 3'd3;
  localparam logic [STATE_W-1:0] CTL_POLL  = 3'd4;

  localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 8'h80;

  typedef enum logic [STATE_W-1:0] {
    ST_READY = CTL_READY,
    ST_ACK1  = CTL_ACK1,
    ST_ACK2  = CTL_ACK2,
    ST_ACK3  = CTL_ACK3,
    ST_POLL  = CTL_POLL
  } ctl_state_t;

  // Level captured at the first INTA; an empty request reads back as IR7.
  function automatic logic [LEVEL_W-1:0] ack_level(input logic [LEVEL_W-1:0] req);
    return (req == '0) ? SPURIOUS_LEVEL : req;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// Bundle of the sequencer's control inputs and ISR/data-bus facing outputs.
interface interrupt_ack_sequencer_if;
  import pic8259_pkg::*;

  logic                 interrupt_acknowledge_n;
  logic                 read;
  logic                 poll_command;
  logic                 icw1_write;
  logic                 u8086_or_mcs80_config;
  logic                 auto_eoi_config;
  logic [LEVEL_W-1:0]   highest_level_in_request;
  logic [STATE_W-1:0]   control_state;
  logic [LEVEL_W-1:0]   interrupt_when_ack1;
  logic                 freeze;
  logic [LEVEL_W-1:0]   latch_in_service;
  logic [LEVEL_W-1:0]   clear_in_service;
  logic                 end_of_sequence;

  modport master (
    output interrupt_acknowledge_n, read, poll_command, icw1_write,
           u8086_or_mcs80_config, auto_eoi_config, highest_level_in_request,
    input  control_state, interrupt_when_ack1, freeze, latch_in_service,
           clear_in_service, end_of_sequence
  );

  modport slave (
    input  interrupt_acknowledge_n, read, poll_command, icw1_write,
           u8086_or_mcs80_config, auto_eoi_config, highest_level_in_request,
    output control_state, interrupt_when_ack1, freeze, latch_in_service,
           clear_in_service, end_of_sequence
  );

endinterface

// File: rtl/interrupt_ack_sequencer_edge_detect.sv
// Rise/fall pulses against a registered copy of the input (input is already synchronised).
module pic_edge_detect #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  output logic rise_c,
  output logic fall_c
);

  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) prev_q <= RESET_VALUE;
    else       prev_q <= sig;
  end

  assign rise_c = sig & ~prev_q;
  assign fall_c = ~sig & prev_q;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259A INTA / OCW3-poll sequencer driving control_state and ISR set/clear strobes.
// Optional ACK_TIMEOUT_EN: abort an acknowledge sequence stalled for TIMEOUT_CYCLES clocks.
module interrupt_ack_sequencer
  import pic8259_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                 clock,
  input logic                 reset,
  interrupt_ack_sequencer_if.slave bus
);

  ctl_state_t state_q, state_d;
  logic inta_fall, inta_rise, read_fall, read_rise_unused;
  logic start_ack, complete, poll_done, timeout;
  logic in_ack;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  pic_edge_detect #(.RESET_VALUE(1'b1)) u_inta_edge (
    .clock  (clock),
    .reset  (reset),
    .sig    (bus.interrupt_acknowledge_n),
    .rise_c (inta_rise),
    .fall_c (inta_fall)
  );

  pic_edge_detect #(.RESET_VALUE(1'b0)) u_read_edge (
    .clock  (clock),
    .reset  (reset),
    .sig    (bus.read),
    .rise_c (read_rise_unused),
    .fall_c (read_fall)
  );

  assign in_ack = (state_q == ST_ACK1) || (state_q == ST_ACK2) || (state_q == ST_ACK3);

`ifdef ACK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Counts stall time between INTA edges; any edge or leaving the ACK states restarts it.
  always_ff @(posedge clock) begin
    if (reset || bus.icw1_write)             cnt_q <= '0;
    else if (inta_fall || inta_rise || !in_ack) cnt_q <= '0;
    else                                     cnt_q <= cnt_q + CNT_W'(1);
  end

  assign timeout = in_ack && !inta_fall && !inta_rise &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_READY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_ack = 1'b0;
    complete  = 1'b0;
    poll_done = 1'b0;
    unique case (state_q)
      ST_READY: begin
        if (inta_fall) begin
          state_d   = ST_ACK1;
          start_ack = 1'b1;
        end else if (bus.poll_command) begin
          state_d = ST_POLL;
        end
      end
      ST_ACK1: if (inta_fall) state_d = ST_ACK2;
      ST_ACK2: begin
        if (!bus.u8086_or_mcs80_config && inta_rise) begin
          state_d  = ST_READY;
          complete = 1'b1;
        end else if (bus.u8086_or_mcs80_config && inta_fall) begin
          state_d = ST_ACK3;
        end
      end
      ST_ACK3: begin
        if (inta_rise) begin
          state_d  = ST_READY;
          complete = 1'b1;
        end
      end
      ST_POLL: begin
        // A new INTA abandons the poll and starts a normal acknowledge.
        if (inta_fall) begin
          state_d   = ST_ACK1;
          start_ack = 1'b1;
        end else if (read_fall) begin
          state_d   = ST_READY;
          poll_done = 1'b1;
        end
      end
      default: state_d = ST_READY;
    endcase
    if (timeout) state_d = ST_READY;
    if (bus.icw1_write) begin
      state_d   = ST_READY;
      start_ack = 1'b0;
      complete  = 1'b0;
      poll_done = 1'b0;
    end
  end

  // Strobes default low every clock so each is a single-cycle pulse.
  always_ff @(posedge clock) begin
    if (reset || bus.icw1_write) begin
      bus.interrupt_when_ack1 <= '0;
      bus.freeze              <= 1'b0;
      bus.latch_in_service    <= '0;
      bus.clear_in_service    <= '0;
      bus.end_of_sequence     <= 1'b0;
    end else begin
      bus.latch_in_service <= '0;
      bus.clear_in_service <= '0;
      bus.end_of_sequence  <= 1'b0;
      if (start_ack) begin
        bus.interrupt_when_ack1 <= ack_level(bus.highest_level_in_request);
        bus.latch_in_service    <= ack_level(bus.highest_level_in_request);
        bus.freeze              <= 1'b1;
      end
      if (complete) begin
        bus.end_of_sequence <= 1'b1;
        bus.freeze          <= 1'b0;
        if (bus.auto_eoi_config) bus.clear_in_service <= bus.interrupt_when_ack1;
      end
      if (poll_done) begin
        bus.latch_in_service <= bus.highest_level_in_request;
        bus.end_of_sequence  <= 1'b1;
      end
      if (timeout) bus.freeze <= 1'b0;
    end
  end

  assign bus.control_state = state_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Scoreboard bench: directed INTA/poll/abort sequences with hand-computed output events.
module tb_interrupt_ack_sequencer;

`ifdef ACK_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 16;
`else
  localparam int unsigned TO_CYCLES = 1024;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] iwa;
    logic       frz;
    logic [7:0] lis;
    logic [7:0] cis;
    logic       eos;
  } obs_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  obs_t sb[$];

  interrupt_ack_sequencer_if bus();

  interrupt_ack_sequencer #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_ev(input logic [2:0] st, input logic [7:0] iwa, input logic frz,
                           input logic [7:0] lis, input logic [7:0] cis, input logic eos);
    obs_t o;
    o.st = st; o.iwa = iwa; o.frz = frz; o.lis = lis; o.cis = cis; o.eos = eos;
    sb.push_back(o);
  endtask

  task automatic pulse();
    bus.interrupt_acknowledge_n = 1'b0;
    step(2);
    bus.interrupt_acknowledge_n = 1'b1;
    step(2);
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: any state change or strobe is an event that must match the next queued entry.
  initial begin
    obs_t got, want;
    logic [2:0] prev_st;
    int   ev;
    ev = 0;
    prev_st = 3'd0;
    @(posedge clock);
    forever begin
      @(negedge clock);
      got.st  = bus.control_state;
      got.iwa = bus.interrupt_when_ack1;
      got.frz = bus.freeze;
      got.lis = bus.latch_in_service;
      got.cis = bus.clear_in_service;
      got.eos = bus.end_of_sequence;
      if (got.st !== prev_st || got.lis !== 8'h00 || got.cis !== 8'h00 || got.eos !== 1'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL event%0d unexpected st=%0d iwa=%h frz=%b lis=%h cis=%h eos=%b",
                   ev, got.st, got.iwa, got.frz, got.lis, got.cis, got.eos);
        end else begin
          want = sb.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL event%0d got st=%0d iwa=%h frz=%b lis=%h cis=%h eos=%b want st=%0d iwa=%h frz=%b lis=%h cis=%h eos=%b",
                     ev, got.st, got.iwa, got.frz, got.lis, got.cis, got.eos,
                     want.st, want.iwa, want.frz, want.lis, want.cis, want.eos);
          end
        end
        ev++;
      end
      prev_st = got.st;
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.interrupt_acknowledge_n  = 1'b1;
    bus.read                     = 1'b0;
    bus.poll_command             = 1'b0;
    bus.icw1_write               = 1'b0;
    bus.u8086_or_mcs80_config    = 1'b0;
    bus.auto_eoi_config          = 1'b0;
    bus.highest_level_in_request = 8'h00;
    step(2);
    reset = 1'b0;
    step(1);

    check_val("reset_state", 8'(bus.control_state), 8'h00);
    check_val("reset_iwa", bus.interrupt_when_ack1, 8'h00);
    check_val("reset_freeze", 8'(bus.freeze), 8'h00);
    check_val("reset_lis", bus.latch_in_service, 8'h00);
    check_val("reset_cis", bus.clear_in_service, 8'h00);
    check_val("reset_eos", 8'(bus.end_of_sequence), 8'h00);

    // 8086 two-pulse acknowledge
    bus.highest_level_in_request = 8'h04;
    expect_ev(3'd1, 8'h04, 1'b1, 8'h04, 8'h00, 1'b0);
    expect_ev(3'd2, 8'h04, 1'b1, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd0, 8'h04, 1'b0, 8'h00, 8'h00, 1'b1);
    pulse(); pulse(); step(2);

    // MCS-80 three pulses with auto-EOI
    bus.u8086_or_mcs80_config = 1'b1;
    bus.auto_eoi_config = 1'b1;
    bus.highest_level_in_request = 8'h10;
    expect_ev(3'd1, 8'h10, 1'b1, 8'h10, 8'h00, 1'b0);
    expect_ev(3'd2, 8'h10, 1'b1, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd3, 8'h10, 1'b1, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd0, 8'h10, 1'b0, 8'h00, 8'h10, 1'b1);
    pulse(); pulse(); pulse(); step(2);
    bus.u8086_or_mcs80_config = 1'b0;
    bus.auto_eoi_config = 1'b0;

    // Spurious: nothing requested at first INTA
    bus.highest_level_in_request = 8'h00;
    expect_ev(3'd1, 8'h80, 1'b1, 8'h80, 8'h00, 1'b0);
    expect_ev(3'd2, 8'h80, 1'b1, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd0, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1);
    pulse(); pulse(); step(2);

    // Poll with a pending level, then poll with none
    bus.highest_level_in_request = 8'h02;
    expect_ev(3'd4, 8'h80, 1'b0, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd0, 8'h80, 1'b0, 8'h02, 8'h00, 1'b1);
    expect_ev(3'd4, 8'h80, 1'b0, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd0, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 2; k++) begin
      bus.read = 1'b1;
      step(1);
      bus.poll_command = 1'b1;
      step(1);
      bus.poll_command = 1'b0;
      step(2);
      bus.read = 1'b0;
      step(2);
      bus.highest_level_in_request = 8'h00;
    end

    // INTA during POLL abandons the poll
    expect_ev(3'd4, 8'h80, 1'b0, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd1, 8'h08, 1'b1, 8'h08, 8'h00, 1'b0);
    expect_ev(3'd2, 8'h08, 1'b1, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd0, 8'h08, 1'b0, 8'h00, 8'h00, 1'b1);
    bus.poll_command = 1'b1;
    step(1);
    bus.poll_command = 1'b0;
    bus.highest_level_in_request = 8'h08;
    step(1);
    pulse(); pulse(); step(2);

    // INTA fall and poll_command together: INTA wins
    bus.highest_level_in_request = 8'h04;
    expect_ev(3'd1, 8'h04, 1'b1, 8'h04, 8'h00, 1'b0);
    expect_ev(3'd2, 8'h04, 1'b1, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd0, 8'h04, 1'b0, 8'h00, 8'h00, 1'b1);
    bus.interrupt_acknowledge_n = 1'b0;
    bus.poll_command = 1'b1;
    step(1);
    bus.poll_command = 1'b0;
    step(1);
    bus.interrupt_acknowledge_n = 1'b1;
    step(2);
    pulse(); step(2);

    // icw1_write in ACK2 aborts with no strobes
    bus.highest_level_in_request = 8'h20;
    expect_ev(3'd1, 8'h20, 1'b1, 8'h20, 8'h00, 1'b0);
    expect_ev(3'd2, 8'h20, 1'b1, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    pulse();
    bus.interrupt_acknowledge_n = 1'b0;
    step(2);
    bus.icw1_write = 1'b1;
    step(1);
    bus.icw1_write = 1'b0;
    step(1);
    bus.interrupt_acknowledge_n = 1'b1;
    step(3);

    // Reset in ACK1 aborts likewise
    bus.highest_level_in_request = 8'h40;
    expect_ev(3'd1, 8'h40, 1'b1, 8'h40, 8'h00, 1'b0);
    expect_ev(3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    bus.interrupt_acknowledge_n = 1'b0;
    step(2);
    reset = 1'b1;
    bus.interrupt_acknowledge_n = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);

    // Stall in ACK1
    bus.highest_level_in_request = 8'h01;
    expect_ev(3'd1, 8'h01, 1'b1, 8'h01, 8'h00, 1'b0);
`ifdef ACK_TIMEOUT_EN
    expect_ev(3'd0, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0);
`endif
    bus.interrupt_acknowledge_n = 1'b0;
    step(100);
`ifdef ACK_TIMEOUT_EN
    check_val("stall_state", 8'(bus.control_state), 8'h00);
    bus.interrupt_acknowledge_n = 1'b1;
    step(3);
`else
    check_val("stall_state", 8'(bus.control_state), 8'h01);
    bus.interrupt_acknowledge_n = 1'b1;
    step(2);
    expect_ev(3'd2, 8'h01, 1'b1, 8'h00, 8'h00, 1'b0);
    expect_ev(3'd0, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1);
    pulse();
`endif
    step(4);

    check_val("pending_events", 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
